// File: rtl/apb_slave_pkg.sv
// Shared types and helpers for the APB wait-state completer.
//   state_e  : two-state transfer FSM encoding
//   WAIT_W   : width of the programmable wait-state count
//   CNT_W    : width of the completed-transfer counter
//   addr_err : out-of-window / misaligned address decode
package apb_slave_pkg;

  localparam int WAIT_W = 4;
  localparam int CNT_W  = 16;

  typedef enum logic {ST_IDLE, ST_ACCESS} state_e;

  // Evaluated in 64 bits so base + 4*depth cannot wrap for any 32-bit window.
  function automatic logic addr_err(input logic [63:0] addr,
                                    input logic [63:0] base,
                                    input logic [63:0] depth);
    logic [63:0] lim;
    lim = base + (depth << 2);
    return (addr[1:0] != 2'b00) || (addr < base) || (addr >= lim);
  endfunction

endpackage

// File: rtl/apb_wait_slave_if.sv
// APB3 bus bundle between the bridge (master) and this completer (slave).
//   psel/penable/pwrite/paddr/pwdata : requester -> completer
//   prdata/pready/pslverr            : completer -> requester
interface apb_wait_slave_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              psel;
  logic              penable;
  logic              pwrite;
  logic [ADDR_W-1:0] paddr;
  logic [DATA_W-1:0] pwdata;
  logic [DATA_W-1:0] prdata;
  logic              pready;
  logic              pslverr;

  modport master (output psel, penable, pwrite, paddr, pwdata,
                  input  prdata, pready, pslverr);
  modport slave  (input  psel, penable, pwrite, paddr, pwdata,
                  output prdata, pready, pslverr);
endinterface

// File: rtl/apb_slave_regfile.sv
// DEPTH x DATA_W word memory, cleared by synchronous reset.
//   clk/rst_n     : clock, synchronous active-low clear
//   we/waddr/wdata: single write port, written on rising edge
//   raddr/rdata   : combinational read port
module apb_slave_regfile #(
  parameter int DEPTH  = 16,
  parameter int DATA_W = 32,
  parameter int IDX_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [IDX_W-1:0]  waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [IDX_W-1:0]  raddr,
  output logic [DATA_W-1:0] rdata
);
  logic [DEPTH-1:0][DATA_W-1:0] mem_q;

  always_ff @(posedge clk) begin
    if (!rst_n)  mem_q <= '0;
    else if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];
endmodule

// File: rtl/apb_wait_slave.sv
// APB3 completer with a small register memory and programmable wait states.
//   hclk/hresetn : clock, synchronous active-low reset
//   apb          : APB3 slave bundle (psel/penable/pwrite/paddr/pwdata in,
//                  prdata/pready/pslverr out)
//   wait_cfg     : wait states per transfer, captured in the setup phase
//   xfer_cnt     : completed transfers (errored ones included), wrapping
module apb_wait_slave
  import apb_slave_pkg::*;
#(
  parameter int              ADDR_W    = 32,
  parameter int              DATA_W    = 32,
  parameter int              DEPTH     = 16,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 32'h8000_0000
) (
  input  logic              hclk,
  input  logic              hresetn,
  apb_wait_slave_if.slave   apb,
  input  logic [WAIT_W-1:0] wait_cfg,
  output logic [CNT_W-1:0]  xfer_cnt
);
  localparam int IDX_W = $clog2(DEPTH);

  state_e             state_q, state_d;
  logic [WAIT_W-1:0]  wait_q,  wait_d;
  logic [ADDR_W-1:0]  addr_q,  addr_d;
  logic [DATA_W-1:0]  wdata_q, wdata_d;
  logic               write_q, write_d;
  logic [CNT_W-1:0]   cnt_q,   cnt_d;

  logic               ready, err, we;
  logic [IDX_W-1:0]   idx;
  logic [DATA_W-1:0]  rdata;

  // Decode works only on latched state, so outputs never depend on inputs.
  assign err   = addr_err(64'(addr_q), 64'(BASE_ADDR), 64'(DEPTH));
  assign idx   = IDX_W'((addr_q - BASE_ADDR) >> 2);
  assign ready = (state_q == ST_ACCESS) && (wait_q == '0);

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    write_d = write_q;
    cnt_d   = cnt_q;
    we      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // psel with penable already high is a protocol violation: ignored.
        if (apb.psel && !apb.penable) begin
          addr_d  = apb.paddr;
          wdata_d = apb.pwdata;
          write_d = apb.pwrite;
          wait_d  = wait_cfg;
          state_d = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        if (!apb.psel) begin
          state_d = ST_IDLE;
        end else if (wait_q != '0) begin
          wait_d = wait_q - WAIT_W'(1);
        end else if (apb.penable) begin
          state_d = ST_IDLE;
          cnt_d   = cnt_q + CNT_W'(1);
          we      = write_q && !err;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge hclk) begin
    if (!hresetn) begin
      state_q <= ST_IDLE;
      wait_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      write_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      write_q <= write_d;
      cnt_q   <= cnt_d;
    end
  end

  apb_slave_regfile #(.DEPTH(DEPTH), .DATA_W(DATA_W), .IDX_W(IDX_W)) u_regfile (
    .clk   (hclk),
    .rst_n (hresetn),
    .we    (we),
    .waddr (idx),
    .wdata (wdata_q),
    .raddr (idx),
    .rdata (rdata)
  );

  assign apb.pready  = ready;
  assign apb.pslverr = ready && err;
  assign apb.prdata  = (ready && !write_q && !err) ? rdata : '0;
  assign xfer_cnt    = cnt_q;
endmodule

// File: tb/tb_apb_wait_slave.sv
module tb_apb_wait_slave;
  logic        hclk = 1'b0;
  logic        hresetn;
  logic [3:0]  wait_cfg;
  logic [15:0] xfer_cnt;

  apb_wait_slave_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  apb_wait_slave dut (
    .hclk     (hclk),
    .hresetn  (hresetn),
    .apb      (bus),
    .wait_cfg (wait_cfg),
    .xfer_cnt (xfer_cnt)
  );

  always #5 hclk = ~hclk;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  cfg;
    logic        chg;     // drop wait_cfg to 0 once the access phase starts
    logic [31:0] exp_rd;
    logic        exp_err;
    int          exp_w;
  } vec_t;

  vec_t vec[18];
  int   n_cmp  = 0;
  int   n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic run_vec(input int i);
    vec_t v;
    int   waits;
    bit   done;
    v = vec[i];
    @(posedge hclk); #1;
    bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = v.wr;
    bus.paddr = v.addr; bus.pwdata = v.wdata; wait_cfg = v.cfg;
    @(posedge hclk); #1;
    bus.penable = 1'b1;
    if (v.chg) wait_cfg = 4'd0;
    waits = 0;
    done  = 1'b0;
    while (!done) begin
      @(negedge hclk);
      if (bus.pready) done = 1'b1;
      else begin
        waits++;
        if (waits > 40) begin
          n_cmp++; n_fail++;
          $display("FAIL v%0d timeout: pready never rose within 40 cycles", i);
          done = 1'b1;
        end
      end
    end
    chk($sformatf("v%0d prdata", i), bus.prdata, v.exp_rd);
    chk($sformatf("v%0d pslverr", i), {31'd0, bus.pslverr}, {31'd0, v.exp_err});
    chk($sformatf("v%0d waits", i), waits, v.exp_w);
  endtask

  task automatic go_idle();
    @(posedge hclk); #1;
    bus.psel = 1'b0; bus.penable = 1'b0;
  endtask

  task automatic setup_a5();
    @(posedge hclk); #1;
    bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = 1'b1;
    bus.paddr = 32'h8000_0004; bus.pwdata = 32'hA5A5_A5A5; wait_cfg = 4'd5;
    @(posedge hclk); #1;
    bus.penable = 1'b1;
    @(negedge hclk); chk("a5 acc1 pready", {31'd0, bus.pready}, 32'd0);
    @(negedge hclk); chk("a5 acc2 pready", {31'd0, bus.pready}, 32'd0);
  endtask

  initial begin
    //          wr    addr           wdata          cfg  chg   exp_rd         err   w
    vec[0]  = '{1'b1, 32'h8000_0008, 32'hDEAD_BEEF, 4'd0, 1'b0, 32'h0,         1'b0, 0};
    vec[1]  = '{1'b0, 32'h8000_0008, 32'h0,         4'd0, 1'b0, 32'hDEAD_BEEF, 1'b0, 0};
    vec[2]  = '{1'b0, 32'h8000_0000, 32'h0,         4'd3, 1'b1, 32'h0,         1'b0, 3};
    vec[3]  = '{1'b1, 32'h8000_0040, 32'h1234_5678, 4'd0, 1'b0, 32'h0,         1'b1, 0};
    vec[4]  = '{1'b0, 32'h8000_0002, 32'h0,         4'd0, 1'b0, 32'h0,         1'b1, 0};
    vec[5]  = '{1'b1, 32'h8000_000A, 32'h1111_1111, 4'd2, 1'b0, 32'h0,         1'b1, 2};
    vec[6]  = '{1'b0, 32'h7FFF_FFFC, 32'h0,         4'd0, 1'b0, 32'h0,         1'b1, 0};
    vec[7]  = '{1'b0, 32'h8000_0000, 32'h0,         4'd0, 1'b0, 32'h0,         1'b0, 0};
    vec[8]  = '{1'b0, 32'h8000_0008, 32'h0,         4'd0, 1'b0, 32'hDEAD_BEEF, 1'b0, 0};
    vec[9]  = '{1'b0, 32'h8000_003C, 32'h0,         4'd1, 1'b0, 32'h0,         1'b0, 1};
    vec[10] = '{1'b1, 32'h8000_0000, 32'hA000_0000, 4'd1, 1'b0, 32'h0,         1'b0, 1};
    vec[11] = '{1'b1, 32'h8000_0004, 32'hA111_0001, 4'd1, 1'b0, 32'h0,         1'b0, 1};
    vec[12] = '{1'b1, 32'h8000_0008, 32'hA222_0002, 4'd1, 1'b0, 32'h0,         1'b0, 1};
    vec[13] = '{1'b1, 32'h8000_000C, 32'hA333_0003, 4'd1, 1'b0, 32'h0,         1'b0, 1};
    vec[14] = '{1'b0, 32'h8000_0000, 32'h0,         4'd1, 1'b0, 32'hA000_0000, 1'b0, 1};
    vec[15] = '{1'b0, 32'h8000_0004, 32'h0,         4'd1, 1'b0, 32'hA111_0001, 1'b0, 1};
    vec[16] = '{1'b0, 32'h8000_0008, 32'h0,         4'd1, 1'b0, 32'hA222_0002, 1'b0, 1};
    vec[17] = '{1'b0, 32'h8000_000C, 32'h0,         4'd1, 1'b0, 32'hA333_0003, 1'b0, 1};

    hresetn = 1'b0; wait_cfg = 4'd0;
    bus.psel = 1'b0; bus.penable = 1'b0; bus.pwrite = 1'b0;
    bus.paddr = 32'h0; bus.pwdata = 32'h0;
    repeat (2) @(posedge hclk);
    #1 hresetn = 1'b1;
    @(negedge hclk);
    chk("reset pready",   {31'd0, bus.pready},  32'd0);
    chk("reset pslverr",  {31'd0, bus.pslverr}, 32'd0);
    chk("reset prdata",   bus.prdata,           32'd0);
    chk("reset xfer_cnt", {16'd0, xfer_cnt},    32'd0);

    for (int i = 0; i < 2; i++) run_vec(i);
    go_idle();
    @(negedge hclk); chk("cnt after zero-wait", {16'd0, xfer_cnt}, 32'd2);

    for (int i = 2; i < 10; i++) run_vec(i);
    go_idle();
    @(negedge hclk); chk("cnt after errors", {16'd0, xfer_cnt}, 32'd10);

    // Abort: psel drops after two access cycles of a 5-wait write.
    setup_a5();
    @(posedge hclk); #1;
    bus.psel = 1'b0; bus.penable = 1'b0;
    repeat (2) @(negedge hclk);
    chk("abort pready",   {31'd0, bus.pready}, 32'd0);
    chk("abort xfer_cnt", {16'd0, xfer_cnt},   32'd10);
    vec[0] = '{1'b0, 32'h8000_0004, 32'h0, 4'd0, 1'b0, 32'h0, 1'b0, 0};
    run_vec(0);  // zero-wait accept proves IDLE; word still 0
    go_idle();
    @(negedge hclk); chk("cnt after abort read", {16'd0, xfer_cnt}, 32'd11);

    // Reset mid-access; bus left in access phase across the reset.
    setup_a5();
    @(posedge hclk); #1 hresetn = 1'b0;
    @(posedge hclk); #1 hresetn = 1'b1;
    @(negedge hclk);
    chk("midrst pready",   {31'd0, bus.pready},  32'd0);
    chk("midrst pslverr",  {31'd0, bus.pslverr}, 32'd0);
    chk("midrst prdata",   bus.prdata,           32'd0);
    chk("midrst xfer_cnt", {16'd0, xfer_cnt},    32'd0);
    @(negedge hclk);
    chk("midrst ignore pready", {31'd0, bus.pready}, 32'd0);
    go_idle();
    run_vec(0);  // word 1 still 0
    vec[1] = '{1'b0, 32'h8000_0008, 32'h0, 4'd0, 1'b0, 32'h0, 1'b0, 0};
    run_vec(1);  // reset cleared DEADBEEF
    go_idle();
    @(negedge hclk); chk("cnt after midrst reads", {16'd0, xfer_cnt}, 32'd2);

    for (int i = 10; i < 18; i++) run_vec(i);
    go_idle();
    @(negedge hclk); chk("cnt after back-to-back", {16'd0, xfer_cnt}, 32'd10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
